rvfi_check_sequencer: RTL and testbench

//  Sequences one formal RVFI checker instance (e.g. the causal checker) in the rvformal harness.
//  - Holds the checker in reset for a warm-up window.
//  - Counts retirements across all NRET channels.
//  - Fires the checker's single-cycle `check` in the exact cycle the CHECK_DEPTH-th instruction retires.
//  - Identifies the retiring channel, so the checker's channel index is driven, not hard-coded.
//  - Sits between the core's RVFI bus and the checker's clock/reset/check inputs.

---
 rtl/rvfi_check_sequencer_pkg.sv | 35 +++
 rtl/rvfi_check_sequencer_if.sv | 20 ++
 rtl/rvfi_check_sequencer_select.sv | 39 +++
 rtl/rvfi_check_sequencer.sv | 166 ++++++++++++++++
 tb/tb_rvfi_check_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rvfi_check_sequencer_pkg.sv
//==============================================================================
// Module   : rvfi_check_pkg
// Brief    : Shared types, widths and helpers for the RVFI check sequencer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package rvfi_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WARM = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    localparam int ORDER_W = 64;

    // Saturating add clamped to the all-ones value of a width-bit counter.
    function automatic logic [63:0] sat_add(input logic [63:0] cnt,
                                            input logic [63:0] inc,
                                            input int          width);
        logic [64:0] sum;
        logic [64:0] max;
        sum = {1'b0, cnt} + {1'b0, inc};
        max = (65'd1 << width) - 65'd1;
        if (sum > max) begin
            return max[63:0];
        end
        return sum[63:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/rvfi_check_sequencer_if.sv
//==============================================================================
// Module   : rvfi_check_sequencer_if
// Brief    : RVFI retirement bus (valid + order per channel) with modports.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface rvfi_check_sequencer_if #(
    parameter int NRET = 1
) ();
    import rvfi_check_pkg::*;

    logic [NRET-1:0]         rvfi_valid;
    logic [ORDER_W*NRET-1:0] rvfi_order;

    modport master (output rvfi_valid, output rvfi_order);
    modport slave  (input  rvfi_valid, input  rvfi_order);
endinterface

`default_nettype wire

// File: rtl/rvfi_check_sequencer_select.sv
//==============================================================================
// Module   : rvfi_retire_select
// Brief    : Popcount of the valid vector and location of its k-th set bit.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rvfi_retire_select #(
    parameter int NRET  = 1,
    parameter int K_W   = 16,
    parameter int IDX_W = $clog2(NRET) + 1,
    parameter int POP_W = $clog2(NRET + 1)
) (
    input  logic [NRET-1:0]  valid,
    input  logic [K_W-1:0]   k,
    output logic [POP_W-1:0] pop,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // k is 1-based; k=0 can never match since pop is at least 1 at a set bit.
    always_comb begin
        pop = '0;
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < NRET; i++) begin
            if (valid[i]) begin
                pop = pop + POP_W'(1);
                if (!hit && (K_W'(pop) == k)) begin
                    hit = 1'b1;
                    idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rvfi_check_sequencer.sv
//==============================================================================
// Module   : rvfi_check_sequencer
// Brief    : Warm-up reset, retirement counting and depth-aligned check strobe
//            for one RVFI checker. Optional idle timeout: RVFI_CHECK_TIMEOUT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rvfi_check_sequencer
    import rvfi_check_pkg::*;
#(
    parameter int NRET        = 1,
    parameter int SKIP_CYCLES = 4,
    parameter int CHECK_DEPTH = 8,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 64
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      enable,
    rvfi_check_sequencer_if.slave     rvfi,
    output logic                      checker_reset,
    output logic                      check,
    output logic [$clog2(NRET):0]     check_channel,
    output logic [CNT_W-1:0]          retire_cnt,
    output logic                      done,
    output logic                      order_err,
    output logic                      stall
);

    localparam int IDX_W = $clog2(NRET) + 1;
    localparam int POP_W = $clog2(NRET + 1);

    seq_state_t          state;
    seq_state_t          state_nxt;
    logic [CNT_W-1:0]    warm_cnt;
    logic [CNT_W-1:0]    k;
    logic [CNT_W-1:0]    cnt_next;
    logic [POP_W-1:0]    pop;
    logic                hit;
    logic [IDX_W-1:0]    idx;
    logic [ORDER_W-1:0]  exp_order;
    logic [ORDER_W-1:0]  exp_order_nxt;
    logic                exp_vld;
    logic                exp_vld_nxt;
    logic                ord_bad;
    logic                warm_done;
    logic                any_valid;
    logic                timeout_hit;

    assign any_valid = |rvfi.rvfi_valid;
    assign warm_done = (SKIP_CYCLES <= 1) || (warm_cnt == CNT_W'(SKIP_CYCLES - 1));
    assign k         = (retire_cnt < CNT_W'(CHECK_DEPTH)) ? (CNT_W'(CHECK_DEPTH) - retire_cnt) : '0;
    assign cnt_next  = CNT_W'(sat_add(64'(retire_cnt), 64'(pop), CNT_W));

    rvfi_retire_select #(
        .NRET  (NRET),
        .K_W   (CNT_W),
        .IDX_W (IDX_W),
        .POP_W (POP_W)
    ) u_select (
        .valid (rvfi.rvfi_valid),
        .k     (k),
        .pop   (pop),
        .hit   (hit),
        .idx   (idx)
    );

    assign check         = (state == ST_RUN) && hit;
    assign check_channel = check ? idx : '0;
    assign checker_reset = (state == ST_IDLE) || (state == ST_WARM);
    assign done          = (state == ST_DONE);

    // Walk the channels in ascending order; the very first retirement only seeds exp_order.
    always_comb begin
        exp_order_nxt = exp_order;
        exp_vld_nxt   = exp_vld;
        ord_bad       = 1'b0;
        for (int i = 0; i < NRET; i++) begin
            if (rvfi.rvfi_valid[i]) begin
                if (exp_vld_nxt && (rvfi.rvfi_order[ORDER_W*i +: ORDER_W] != exp_order_nxt)) begin
                    ord_bad = 1'b1;
                end
                exp_order_nxt = (exp_vld_nxt ? exp_order_nxt
                                             : rvfi.rvfi_order[ORDER_W*i +: ORDER_W]) + 64'd1;
                exp_vld_nxt   = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (enable) state_nxt = ST_WARM;
            ST_WARM: begin
                if (!enable)        state_nxt = ST_IDLE;
                else if (warm_done) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!enable)          state_nxt = ST_IDLE;
                else if (hit)         state_nxt = ST_DONE;
                else if (timeout_hit) state_nxt = ST_DONE;
            end
            ST_DONE: if (!enable) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            warm_cnt   <= '0;
            retire_cnt <= '0;
            exp_order  <= '0;
            exp_vld    <= 1'b0;
            order_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            warm_cnt <= ((state == ST_WARM) && (state_nxt == ST_WARM)) ? warm_cnt + CNT_W'(1) : '0;
            if (state_nxt == ST_IDLE) begin
                retire_cnt <= '0;
                exp_order  <= '0;
                exp_vld    <= 1'b0;
            end else if (state == ST_RUN) begin
                retire_cnt <= cnt_next;
                exp_order  <= exp_order_nxt;
                exp_vld    <= exp_vld_nxt;
            end
            if ((state == ST_RUN) && enable && ord_bad) begin
                order_err <= 1'b1;
            end
        end
    end

`ifdef RVFI_CHECK_TIMEOUT_EN
    logic [CNT_W-1:0] idle_cnt;

    // A retirement in the would-be timeout cycle wins: any_valid suppresses the hit.
    assign timeout_hit = (state == ST_RUN) && !any_valid && (idle_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            idle_cnt <= '0;
            stall    <= 1'b0;
        end else begin
            if ((state == ST_RUN) && enable && !any_valid && !timeout_hit) begin
                idle_cnt <= idle_cnt + CNT_W'(1);
            end else begin
                idle_cnt <= '0;
            end
            if (timeout_hit && enable) begin
                stall <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = |TIMEOUT;
    assign timeout_hit    = 1'b0;
    assign stall          = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rvfi_check_sequencer.sv
//==============================================================================
// Module   : tb_rvfi_check_sequencer
// Brief    : Directed and randomized self-checking bench for rvfi_check_sequencer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rvfi_check_sequencer;

    localparam int NRET  = 2;
    localparam int SKIP  = 4;
    localparam int DEPTH = 3;
    localparam int CNT_W = 16;
    localparam int TMO   = 8;

    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic             enable = 1'b0;
    logic             checker_reset;
    logic             check;
    logic [1:0]       check_channel;
    logic [CNT_W-1:0] retire_cnt;
    logic             done;
    logic             order_err;
    logic             stall;

    int n_checks = 0;
    int n_pass   = 0;

    rvfi_check_sequencer_if #(.NRET(NRET)) bus ();

    rvfi_check_sequencer #(
        .NRET        (NRET),
        .SKIP_CYCLES (SKIP),
        .CHECK_DEPTH (DEPTH),
        .CNT_W       (CNT_W),
        .TIMEOUT     (TMO)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .enable        (enable),
        .rvfi          (bus.slave),
        .checker_reset (checker_reset),
        .check         (check),
        .check_channel (check_channel),
        .retire_cnt    (retire_cnt),
        .done          (done),
        .order_err     (order_err),
        .stall         (stall)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1);
        bus.rvfi_valid = v;
        bus.rvfi_order = {o1, o0};
        #1;
    endtask

    task automatic apply_reset;
        resetn = 1'b0;
        enable = 1'b0;
        drive(2'b00, 64'd0, 64'd0);
        repeat (2) tick;
        #3 resetn = 1'b1;
    endtask

    task automatic go_run;
        enable = 1'b1;
        repeat (SKIP + 1) tick;
    endtask

    task automatic test_reset;
        apply_reset;
        tick;
        n_checks++; if (checker_reset !== 1'b1) $display("FAIL reset_checker_reset got=%0b exp=1", checker_reset); else n_pass++;
        n_checks++; if (check !== 1'b0) $display("FAIL reset_check got=%0b exp=0", check); else n_pass++;
        n_checks++; if (check_channel !== 2'd0) $display("FAIL reset_channel got=%0d exp=0", check_channel); else n_pass++;
        n_checks++; if (retire_cnt !== 16'd0) $display("FAIL reset_retire_cnt got=%0d exp=0", retire_cnt); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%0b exp=0", done); else n_pass++;
        n_checks++; if (order_err !== 1'b0) $display("FAIL reset_order_err got=%0b exp=0", order_err); else n_pass++;
        n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall got=%0b exp=0", stall); else n_pass++;
    endtask

    task automatic test_single_channel;
        apply_reset;
        tick;
        enable = 1'b1;
        for (int i = 1; i <= SKIP + 1; i++) begin
            tick;
            n_checks++;
            if (checker_reset !== (i <= SKIP)) $display("FAIL t1_warm_reset cycle=%0d got=%0b exp=%0b", i, checker_reset, (i <= SKIP));
            else n_pass++;
        end
        for (int r = 0; r < 3; r++) begin
            drive(2'b01, 64'd100 + 64'(r), 64'd0);
            n_checks++;
            if (check !== (r == 2)) $display("FAIL t1_check run_cycle=%0d got=%0b exp=%0b", r, check, (r == 2));
            else n_pass++;
            tick;
        end
        n_checks++; if (check_channel !== 2'd0) $display("FAIL t1_channel_idle got=%0d exp=0", check_channel); else n_pass++;
        drive(2'b00, 64'd0, 64'd0);
        n_checks++; if (done !== 1'b1) $display("FAIL t1_done got=%0b exp=1", done); else n_pass++;
        n_checks++; if (retire_cnt !== 16'd3) $display("FAIL t1_retire_cnt got=%0d exp=3", retire_cnt); else n_pass++;
        n_checks++; if (check !== 1'b0) $display("FAIL t1_check_after got=%0b exp=0", check); else n_pass++;
        n_checks++; if (checker_reset !== 1'b0) $display("FAIL t1_reset_done got=%0b exp=0", checker_reset); else n_pass++;
    endtask

    task automatic test_dual_channel;
        apply_reset;
        tick;
        go_run;
        drive(2'b11, 64'd0, 64'd1);
        n_checks++; if (check !== 1'b0) $display("FAIL t2_check_beat1 got=%0b exp=0", check); else n_pass++;
        tick;
        n_checks++; if (retire_cnt !== 16'd2) $display("FAIL t2_cnt_beat1 got=%0d exp=2", retire_cnt); else n_pass++;
        drive(2'b11, 64'd2, 64'd3);
        n_checks++; if (check !== 1'b1) $display("FAIL t2_check_beat2 got=%0b exp=1", check); else n_pass++;
        n_checks++; if (check_channel !== 2'd0) $display("FAIL t2_channel got=%0d exp=0", check_channel); else n_pass++;
        tick;
        drive(2'b00, 64'd0, 64'd0);
        n_checks++; if (retire_cnt !== 16'd4) $display("FAIL t2_cnt_final got=%0d exp=4", retire_cnt); else n_pass++;
        n_checks++; if (done !== 1'b1) $display("FAIL t2_done got=%0b exp=1", done); else n_pass++;
    endtask

    task automatic test_back_to_back;
        // Target falls on the upper channel of a dual-retire beat.
        apply_reset;
        tick;
        go_run;
        drive(2'b01, 64'd7, 64'd0);
        tick;
        drive(2'b11, 64'd8, 64'd9);
        n_checks++; if (check !== 1'b1) $display("FAIL b2b_check got=%0b exp=1", check); else n_pass++;
        n_checks++; if (check_channel !== 2'd1) $display("FAIL b2b_channel got=%0d exp=1", check_channel); else n_pass++;
        tick;
        drive(2'b11, 64'd10, 64'd11);
        n_checks++; if (check !== 1'b0) $display("FAIL b2b_no_repeat got=%0b exp=0", check); else n_pass++;
        tick;
        n_checks++; if (retire_cnt !== 16'd3) $display("FAIL b2b_cnt got=%0d exp=3", retire_cnt); else n_pass++;
        n_checks++; if (order_err !== 1'b0) $display("FAIL b2b_order_err got=%0b exp=0", order_err); else n_pass++;
    endtask

    task automatic test_order_gap;
        apply_reset;
        tick;
        go_run;
        drive(2'b01, 64'd10, 64'd0);
        tick;
        drive(2'b01, 64'd11, 64'd0);
        tick;
        n_checks++; if (order_err !== 1'b0) $display("FAIL t3_err_early got=%0b exp=0", order_err); else n_pass++;
        drive(2'b01, 64'd13, 64'd0);
        n_checks++; if (check !== 1'b1) $display("FAIL t3_check got=%0b exp=1", check); else n_pass++;
        tick;
        drive(2'b00, 64'd0, 64'd0);
        n_checks++; if (order_err !== 1'b1) $display("FAIL t3_err got=%0b exp=1", order_err); else n_pass++;
        n_checks++; if (done !== 1'b1) $display("FAIL t3_done got=%0b exp=1", done); else n_pass++;
    endtask

    task automatic test_abort;
        apply_reset;
        tick;
        go_run;
        drive(2'b01, 64'd0, 64'd0);
        tick;
        drive(2'b01, 64'd1, 64'd0);
        tick;
        n_checks++; if (retire_cnt !== 16'd2) $display("FAIL t4_cnt_pre got=%0d exp=2", retire_cnt); else n_pass++;
        enable = 1'b0;
        drive(2'b00, 64'd0, 64'd0);
        tick;
        n_checks++; if (checker_reset !== 1'b1) $display("FAIL t4_reset got=%0b exp=1", checker_reset); else n_pass++;
        n_checks++; if (retire_cnt !== 16'd0) $display("FAIL t4_cnt_clr got=%0d exp=0", retire_cnt); else n_pass++;
        enable = 1'b1;
        for (int i = 1; i <= SKIP + 1; i++) begin
            tick;
            n_checks++;
            if (checker_reset !== (i <= SKIP)) $display("FAIL t4_rewarm cycle=%0d got=%0b exp=%0b", i, checker_reset, (i <= SKIP));
            else n_pass++;
        end
        // Stale expected order must not survive the abort.
        drive(2'b01, 64'd500, 64'd0);
        tick;
        drive(2'b00, 64'd0, 64'd0);
        n_checks++; if (order_err !== 1'b0) $display("FAIL t4_order_reseed got=%0b exp=0", order_err); else n_pass++;
        n_checks++; if (retire_cnt !== 16'd1) $display("FAIL t4_cnt_restart got=%0d exp=1", retire_cnt); else n_pass++;
    endtask

    task automatic test_timeout;
        apply_reset;
        tick;
        go_run;
        drive(2'b00, 64'd0, 64'd0);
`ifdef RVFI_CHECK_TIMEOUT_EN
        for (int i = 1; i <= TMO; i++) begin
            n_checks++; if (check !== 1'b0) $display("FAIL t5_check cycle=%0d got=%0b exp=0", i, check); else n_pass++;
            tick;
            n_checks++;
            if (done !== (i >= TMO) || stall !== (i >= TMO))
                $display("FAIL t5_stall cycle=%0d got=%0b/%0b exp=%0b", i, done, stall, (i >= TMO));
            else n_pass++;
        end
        apply_reset;
        tick;
        go_run;
        repeat (TMO - 1) tick;
        drive(2'b01, 64'd0, 64'd0);
        tick;
        drive(2'b00, 64'd0, 64'd0);
        n_checks++; if (stall !== 1'b0 || done !== 1'b0) $display("FAIL t5_priority got=%0b/%0b exp=0/0", stall, done); else n_pass++;
        n_checks++; if (retire_cnt !== 16'd1) $display("FAIL t5_priority_cnt got=%0d exp=1", retire_cnt); else n_pass++;
        repeat (TMO) tick;
        n_checks++; if (stall !== 1'b1 || done !== 1'b1) $display("FAIL t5_rearm got=%0b/%0b exp=1/1", stall, done); else n_pass++;
`else
        for (int i = 1; i <= 3 * TMO; i++) begin
            n_checks++; if (check !== 1'b0) $display("FAIL t5_check cycle=%0d got=%0b exp=0", i, check); else n_pass++;
            tick;
        end
        n_checks++; if (stall !== 1'b0) $display("FAIL t5_stall got=%0b exp=0", stall); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL t5_done got=%0b exp=0", done); else n_pass++;
`endif
    endtask

    task automatic test_async_reset;
        apply_reset;
        tick;
        go_run;
        drive(2'b01, 64'd5, 64'd0);
        tick;
        drive(2'b01, 64'd9, 64'd0);
        tick;
        drive(2'b00, 64'd0, 64'd0);
        n_checks++; if (order_err !== 1'b1) $display("FAIL t6_err_pre got=%0b exp=1", order_err); else n_pass++;
        #2 resetn = 1'b0;
        #1;
        n_checks++; if (checker_reset !== 1'b1) $display("FAIL t6_reset got=%0b exp=1", checker_reset); else n_pass++;
        n_checks++; if (retire_cnt !== 16'd0) $display("FAIL t6_cnt got=%0d exp=0", retire_cnt); else n_pass++;
        n_checks++; if (order_err !== 1'b0) $display("FAIL t6_err got=%0b exp=0", order_err); else n_pass++;
        n_checks++; if (done !== 1'b0 || check !== 1'b0) $display("FAIL t6_done_check got=%0b/%0b exp=0/0", done, check); else n_pass++;
        #2 resetn = 1'b1;
        enable = 1'b0;
    endtask

    task automatic test_random;
        int total;
        int cnt;
        int chan;
        bit fired;
        bit err;
        bit chk_exp;
        bit run;
        longint unsigned q[$];
        logic [63:0] nxt;
        logic [63:0] ord [2];
        logic [1:0] v;
        apply_reset;
        tick;
        err = 1'b0;
        for (int ep = 0; ep < 6; ep++) begin
            total = 0;
            fired = 1'b0;
            q.delete();
            nxt = (ep == 0) ? 64'hFFFF_FFFF_FFFF_FFFE : {$urandom, $urandom};
            enable = 1'b1;
            for (int c = 1; c <= 25; c++) begin
                tick;
                n_checks++;
                if (checker_reset !== (c <= SKIP) || done !== fired || retire_cnt !== 16'(total) || order_err !== err)
                    $display("FAIL rnd_state ep=%0d cyc=%0d got rst=%0b done=%0b cnt=%0d err=%0b exp rst=%0b done=%0b cnt=%0d err=%0b",
                             ep, c, checker_reset, done, retire_cnt, order_err, (c <= SKIP), fired, total, err);
                else n_pass++;
                v = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
                for (int b = 0; b < 2; b++) begin
                    ord[b] = {$urandom, $urandom};
                    if (v[b]) begin
                        if ($urandom_range(0, 15) == 0) nxt = nxt + 64'd2;
                        ord[b] = nxt;
                        nxt = nxt + 64'd1;
                    end
                end
                drive(v, ord[0], ord[1]);
                run = (c > SKIP) && !fired;
                chk_exp = 1'b0;
                chan = 0;
                if (run) begin
                    cnt = 0;
                    for (int b = 0; b < 2; b++) begin
                        if (v[b]) begin
                            cnt++;
                            if (total + cnt == DEPTH) begin
                                chk_exp = 1'b1;
                                chan = b;
                            end
                        end
                    end
                end
                n_checks++;
                if (check !== chk_exp || check_channel !== 2'(chan))
                    $display("FAIL rnd_check ep=%0d cyc=%0d got=%0b ch=%0d exp=%0b ch=%0d", ep, c, check, check_channel, chk_exp, chan);
                else n_pass++;
                if (run) begin
                    for (int b = 0; b < 2; b++) begin
                        if (v[b]) begin
                            if (q.size() > 0 && ord[b] != q[0] + 64'(q.size())) err = 1'b1;
                            q.push_back(ord[b]);
                            total++;
                        end
                    end
                    if (chk_exp) fired = 1'b1;
                end
            end
            enable = 1'b0;
            drive(2'b00, 64'd0, 64'd0);
            tick;
            tick;
            n_checks++;
            if (checker_reset !== 1'b1 || retire_cnt !== 16'd0 || done !== 1'b0)
                $display("FAIL rnd_abort ep=%0d got rst=%0b cnt=%0d done=%0b exp 1/0/0", ep, checker_reset, retire_cnt, done);
            else n_pass++;
        end
    endtask

    initial begin
        bus.rvfi_valid = '0;
        bus.rvfi_order = '0;
        test_reset;
        test_single_channel;
        test_dual_channel;
        test_back_to_back;
        test_order_gap;
        test_abort;
        test_timeout;
        test_async_reset;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
